// File: rtl/fb_pkg.sv
// Shared types for the double-buffered frame store: controller states, read-pipeline metadata
// and the address-width helper.
package fb_pkg;

  typedef enum logic [1:0] {
    RENDER,
    WAIT_SWAP,
    CLEAR
  } fb_state_t;

  typedef struct packed {
    logic vld;
    logic bank;
  } rd_meta_t;

  function automatic int fb_addr_w(input int width, input int height);
    return (width * height > 1) ? $clog2(width * height) : 1;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port frame bank: one write port and one read port with a 1-cycle registered read.
// No backpressure. A read that collides with a write returns the old data.
module fb_ram #(
  parameter int DEPTH  = 57600,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/double_frame_buffer.sv
// Double-buffered frame store: renderer fills the back bank while video scans the front bank with upscaling.
// Read latency is 3 cycles. wr_ready drops from frame_done until the swap and the back-bank clear finish.
module double_frame_buffer
  import fb_pkg::*;
#(
  parameter int                 FB_WIDTH    = 320,
  parameter int                 FB_HEIGHT   = 180,
  parameter int                 PIXEL_W     = 16,
  parameter int                 SCALE_LOG2  = 2,
  parameter bit                 CLEAR_EN    = 1'b1,
  parameter logic [PIXEL_W-1:0] CLEAR_COLOR = '0,
  parameter int                 ADDR_W      = fb_addr_w(FB_WIDTH, FB_HEIGHT)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               wr_valid_in,
  input  logic [ADDR_W-1:0]  wr_addr_in,
  input  logic [PIXEL_W-1:0] wr_data_in,
  output logic               wr_ready_out,
  input  logic               frame_done_in,
  output logic               swap_done_out,
  input  logic               frame_end_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               pixel_valid_out,
  output logic               front_sel_out
);

  localparam int                DEPTH     = FB_WIDTH * FB_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fb_state_t         state, state_nxt;
  logic              front_sel;
  logic [ADDR_W-1:0] clear_addr;
  logic              swap_go, clear_last, swap_done_nxt;

  assign swap_go    = ((state == RENDER) && frame_done_in && frame_end_in) ||
                      ((state == WAIT_SWAP) && frame_end_in);
  assign clear_last = (state == CLEAR) && (clear_addr == LAST_ADDR);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= RENDER;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (swap_go) begin
      state_nxt = CLEAR_EN ? CLEAR : RENDER;
    end else begin
      case (state)
        RENDER:    if (frame_done_in) state_nxt = WAIT_SWAP;
        WAIT_SWAP: state_nxt = WAIT_SWAP;
        CLEAR:     if (clear_last) state_nxt = RENDER;
        default:   state_nxt = RENDER;
      endcase
    end
  end

  always_comb begin
    wr_ready_out  = (state == RENDER);
    swap_done_nxt = clear_last || (swap_go && !CLEAR_EN);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      front_sel     <= 1'b0;
      clear_addr    <= '0;
      swap_done_out <= 1'b0;
    end else begin
      swap_done_out <= swap_done_nxt;
      if (swap_go) begin
        front_sel  <= ~front_sel;
        clear_addr <= '0;
      end else if (state == CLEAR) begin
        clear_addr <= clear_addr + 1'b1;
      end
    end
  end

  assign front_sel_out = front_sel;

  // Only the back bank (the one not on screen) is ever written, by renderer or clear sweep.
  logic               bk_wr_en;
  logic [ADDR_W-1:0]  bk_wr_addr;
  logic [PIXEL_W-1:0] bk_wr_data;
  logic [PIXEL_W-1:0] bank_rd [2];
  logic [ADDR_W-1:0]  s1_addr;

  always_comb begin
    bk_wr_en   = wr_valid_in && wr_ready_out && (32'(wr_addr_in) < DEPTH);
    bk_wr_addr = wr_addr_in;
    bk_wr_data = wr_data_in;
    if (state == CLEAR) begin
      bk_wr_en   = 1'b1;
      bk_wr_addr = clear_addr;
      bk_wr_data = CLEAR_COLOR;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fb_ram #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W),
      .DATA_W(PIXEL_W)
    ) u_ram (
      .clk_in (clk_in),
      .wr_en  (bk_wr_en && (front_sel != 1'(b))),
      .wr_addr(bk_wr_addr),
      .wr_data(bk_wr_data),
      .rd_addr(s1_addr),
      .rd_data(bank_rd[b])
    );
  end

  logic [10:0] hx;
  logic [9:0]  vy;
  logic        in_region;
  rd_meta_t    s1_meta, s2_meta;

  assign hx        = hcount_in >> SCALE_LOG2;
  assign vy        = vcount_in >> SCALE_LOG2;
  assign in_region = (32'(hx) < FB_WIDTH) && (32'(vy) < FB_HEIGHT);

  // The bank select travels with its address so a swap never splits a pixel across banks.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_addr         <= '0;
      s1_meta         <= '0;
      s2_meta         <= '0;
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
    end else begin
      s1_addr         <= in_region ? ADDR_W'(32'(hx) + 32'(FB_WIDTH) * 32'(vy)) : '0;
      s1_meta         <= '{vld: in_region, bank: front_sel};
      s2_meta         <= s1_meta;
      pixel_valid_out <= s2_meta.vld;
      pixel_out       <= s2_meta.vld ? bank_rd[s2_meta.bank] : '0;
    end
  end

endmodule

// File: tb/tb_double_frame_buffer.sv
// Scoreboard bench for double_frame_buffer on a small 20x12 frame with a non-zero clear colour.
module tb_double_frame_buffer;

  localparam int          W     = 20;
  localparam int          H     = 12;
  localparam int          DEPTH = W * H;
  localparam int          AW    = 8;
  localparam logic [15:0] CLR   = 16'h0841;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic          frame_done = 1'b0;
  logic          frame_end = 1'b0;
  logic [10:0]   hcount = '0;
  logic [9:0]    vcount = '0;
  logic          wr_ready, swap_done, pixel_valid, front_sel;
  logic [15:0]   pixel;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;
  bit          rd_req = 1'b0, rq1 = 1'b0, rq2 = 1'b0, rq3 = 1'b0;
  int          busy, pulses, stuck;

  always #5 clk = ~clk;

  double_frame_buffer #(
    .FB_WIDTH(W), .FB_HEIGHT(H), .PIXEL_W(16), .SCALE_LOG2(2),
    .CLEAR_EN(1'b1), .CLEAR_COLOR(CLR)
  ) dut (
    .clk_in(clk), .rst_in(rst_n),
    .wr_valid_in(wr_valid), .wr_addr_in(wr_addr), .wr_data_in(wr_data), .wr_ready_out(wr_ready),
    .frame_done_in(frame_done), .swap_done_out(swap_done), .frame_end_in(frame_end),
    .hcount_in(hcount), .vcount_in(vcount),
    .pixel_out(pixel), .pixel_valid_out(pixel_valid), .front_sel_out(front_sel)
  );

  // Expected arrival of each read: 3 clock edges after it is presented.
  always @(posedge clk) begin
    rq1 <= rd_req;
    rq2 <= rq1;
    rq3 <= rq2;
  end

  always @(negedge clk) begin
    if (rq3) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pix_unexpected: got valid=%0b pixel=%h, required no pending read", pixel_valid, pixel);
      end else begin
        mon_e = exp_q.pop_front();
        if ({pixel_valid, pixel} !== mon_e) begin
          n_fail++;
          $display("FAIL pix_read: got valid=%0b pixel=%h, required valid=%0b pixel=%h",
                   pixel_valid, pixel, mon_e[16], mon_e[15:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wr_valid = 1'b1;
    wr_addr  = AW'(a);
    wr_data  = d;
    check("wr_ready_accept", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input int h, input int v, input logic vld, input logic [15:0] pix);
    hcount = 11'(h);
    vcount = 10'(v);
    rd_req = 1'b1;
    exp_q.push_back({vld, pix});
    tick();
    rd_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("drain_pending_reads", exp_q.size(), 0);
  endtask

  task automatic wait_swap_done();
    for (int i = 0; i < 1000 && !swap_done; i++) tick();
    check("swap_done_seen", swap_done, 1);
    tick();
    check("swap_done_one_pulse", swap_done, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_front_sel", front_sel, 0);
    check("rst_pixel", pixel, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_swap_done", swap_done, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_wr_ready", wr_ready, 1);

    // Frame 1 into bank 1; the last two writes are out of range and dropped.
    wr(0, 16'hF800);
    wr(1, 16'h07E0);
    wr(21, 16'h001F);
    wr(239, 16'hABCD);
    wr(240, 16'hDEAD);
    wr(255, 16'hBEEF);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("wait_wr_ready", wr_ready, 0);
    repeat (5) tick();
    check("wait_front_sel", front_sel, 0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("swap1_front_sel", front_sel, 1);

    // Hold a write during the clear: it must never be accepted.
    wr_valid = 1'b1;
    wr_addr  = 8'd5;
    wr_data  = 16'h1111;
    busy     = 0;
    pulses   = 0;
    for (int i = 0; i < 1000 && !wr_ready; i++) begin
      busy++;
      pulses += int'(swap_done);
      tick();
    end
    wr_valid = 1'b0;
    check("clear_cycles", busy, DEPTH);
    check("clear_no_early_done", pulses, 0);
    check("clear_swap_done", swap_done, 1);
    tick();
    check("clear_swap_done_drop", swap_done, 0);

    rd(0, 0, 1'b1, 16'hF800);
    rd(1, 0, 1'b1, 16'hF800);
    rd(2, 0, 1'b1, 16'hF800);
    rd(3, 0, 1'b1, 16'hF800);
    rd(4, 0, 1'b1, 16'h07E0);
    rd(7, 3, 1'b1, 16'h07E0);
    rd(5, 7, 1'b1, 16'h001F);
    rd(79, 47, 1'b1, 16'hABCD);
    rd(80, 0, 1'b0, 16'h0000);
    rd(0, 48, 1'b0, 16'h0000);
    rd(1279, 100, 1'b0, 16'h0000);
    rd(1279, 720, 1'b0, 16'h0000);
    drain();

    // Simultaneous frame_done/frame_end swaps at once; then scan all of bank 0 while bank 1 clears.
    wr(2, 16'h1234);
    frame_done = 1'b1;
    frame_end  = 1'b1;
    tick();
    frame_done = 1'b0;
    frame_end  = 1'b0;
    check("swap2_front_sel", front_sel, 0);
    check("swap2_wr_ready", wr_ready, 0);
    for (int a = 0; a < DEPTH; a++)
      rd(4 * (a % W) + (a % 4), 4 * (a / W) + ((a / 3) % 4), 1'b1, (a == 2) ? 16'h1234 : CLR);
    wait_swap_done();
    drain();

    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    tick();
    check("render_frame_end_front", front_sel, 0);
    check("render_frame_end_ready", wr_ready, 1);

    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    stuck = 0;
    for (int i = 0; i < 10000; i++) begin
      frame_done = (i % 1000 == 500);
      if (!wr_ready && !front_sel) stuck++;
      tick();
    end
    frame_done = 1'b0;
    check("wait_swap_hold", stuck, 10000);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("swap3_front_sel", front_sel, 1);
    repeat (50) tick();
    check("swap3_clearing", wr_ready, 0);

    rst_n = 1'b0;
    #1;
    check("midclear_rst_ready", wr_ready, 1);
    check("midclear_rst_front", front_sel, 0);
    check("midclear_rst_done", swap_done, 0);
    check("midclear_rst_valid", pixel_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("after_rst_ready", wr_ready, 1);

    // Bank 0 front again: its low addresses were swept before the reset.
    rd(8, 0, 1'b1, CLR);
    rd(79, 47, 1'b1, CLR);
    drain();
    wr(3, 16'h5555);
    frame_done = 1'b1;
    frame_end  = 1'b1;
    tick();
    frame_done = 1'b0;
    frame_end  = 1'b0;
    check("swap4_front_sel", front_sel, 1);
    rd(12, 0, 1'b1, 16'h5555);
    rd(0, 0, 1'b1, CLR);
    rd(40, 4, 1'b1, CLR);
    wait_swap_done();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1);
  end

endmodule
